// File: rtl/mjolnir_seq_addsub_if.sv
// Bus bundle for mjolnir_seq_addsub: operation request in, status/result out.
interface mjolnir_seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/mjolnir_seq_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, carry held in a
// register between cycles. Subtract is a + ~b + 1 (carry-in = sub).
module mjolnir_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mjolnir_seq_addsub_if.slave  bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH-1:0]  r_part;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK:0]    w_chunk_sum;
  logic [WIDTH-1:0]  w_result;
  logic              w_last;
  logic              w_ovf;

  // Select the current operand chunks and merge this cycle's chunk into the
  // partial result, so the final cycle can publish the complete sum directly.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_chunk = r_opa[k*CHUNK +: CHUNK];
        w_b_chunk = r_opb[k*CHUNK +: CHUNK];
      end
    end
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_result    = r_part;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_result[k*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
      end
    end
    w_last = (r_idx == IDXW'(N - 1));
    w_ovf  = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_result[WIDTH-1] != r_opa[WIDTH-1]);
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus operand capture, chunk datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_part  <= w_result;
          r_carry <= w_chunk_sum[CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_sum  <= w_result;
            r_cout <= w_chunk_sum[CHUNK];
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_mjolnir_seq_addsub.sv
// Directed bench for mjolnir_seq_addsub in three configurations:
// 16/4 (main), 32/8 and 16/16.
module tb_mjolnir_seq_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mjolnir_seq_addsub_if #(.WIDTH(16)) d16 ();
  mjolnir_seq_addsub_if #(.WIDTH(32)) d32 ();
  mjolnir_seq_addsub_if #(.WIDTH(16)) d1c ();

  mjolnir_seq_addsub #(.WIDTH(16), .CHUNK(4))  u16 (.clk(clk), .rst_n(rst_n), .bus(d16));
  mjolnir_seq_addsub #(.WIDTH(32), .CHUNK(8))  u32 (.clk(clk), .rst_n(rst_n), .bus(d32));
  mjolnir_seq_addsub #(.WIDTH(16), .CHUNK(16)) u1c (.clk(clk), .rst_n(rst_n), .bus(d1c));

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // One full 16/4 operation: start for one cycle, scramble inputs afterwards,
  // then check latency, busy length, result and the single-cycle done pulse.
  task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    int bc;
    @(negedge clk);
    d16.a = a; d16.b = b; d16.sub = s; d16.start = 1'b1;
    @(negedge clk);
    d16.start = 1'b0; d16.a = 16'hDEAD; d16.b = 16'hBEEF; d16.sub = ~s;
    lat = 1; bc = 0;
    while (!d16.done && lat < 20) begin
      bc += int'(d16.busy);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"},  64'(lat), 64'd5);
    chk({nm, "_busy"}, 64'(bc), 64'd4);
    chk({nm, "_sum"},  64'(d16.sum), 64'(es));
    chk({nm, "_cout"}, 64'(d16.cout), 64'(ec));
    chk({nm, "_ovf"},  64'(d16.ovf), 64'(eo));
    @(negedge clk);
    chk({nm, "_done_low"}, 64'(d16.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    int first;
    int last;
    logic [15:0] prev;

    tbl[0] = '{"add_small",   16'd123,   16'd456,   1'b0, 16'd579,   1'b0, 1'b0};
    tbl[1] = '{"add_posovf",  16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0, 1'b1};
    tbl[2] = '{"add_negovf",  16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b1};
    tbl[3] = '{"add_wrap",    16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0};
    tbl[4] = '{"sub_7_5",     16'd7,     16'd5,     1'b1, 16'd2,     1'b1, 1'b0};
    tbl[5] = '{"sub_5_7",     16'd5,     16'd7,     1'b1, 16'hFFFE,  1'b0, 1'b0};
    tbl[6] = '{"sub_ovf",     16'h8000,  16'h0001,  1'b1, 16'h7FFF,  1'b1, 1'b1};
    tbl[7] = '{"sub_equal",   16'h1234,  16'h1234,  1'b1, 16'h0000,  1'b1, 1'b0};
    tbl[8] = '{"add_negpos",  16'h8000,  16'hFFFF,  1'b0, 16'h7FFF,  1'b1, 1'b1};

    d16.start = 1'b0; d16.sub = 1'b0; d16.a = '0; d16.b = '0;
    d32.start = 1'b0; d32.sub = 1'b0; d32.a = '0; d32.b = '0;
    d1c.start = 1'b0; d1c.sub = 1'b0; d1c.a = '0; d1c.b = '0;

    // Reset held while the request lines toggle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d16.start = ~d16.start; d16.a = 16'hFFFF; d16.b = 16'h1111;
      #1;
      chk("rst_hold_outs", 64'({d16.busy, d16.done, d16.sum, d16.cout, d16.ovf}), 64'd0);
    end
    @(negedge clk);
    d16.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_outs", 64'({d16.busy, d16.done, d16.sum, d16.cout, d16.ovf}), 64'd0);

    foreach (tbl[i]) op16(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].o);
    prev = tbl[8].s;

    // start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    d16.a = 16'd100; d16.b = 16'd1; d16.sub = 1'b0; d16.start = 1'b1;
    @(negedge clk);
    d16.start = 1'b0;
    chk("ign_hold_sum1", 64'(d16.sum), 64'(prev));
    @(negedge clk);
    d16.a = 16'd999; d16.b = 16'd999; d16.sub = 1'b1; d16.start = 1'b1;
    chk("ign_busy", 64'(d16.busy), 64'd1);
    @(negedge clk);
    d16.start = 1'b0;
    chk("ign_hold_sum3", 64'(d16.sum), 64'(prev));
    lat = 3;
    while (!d16.done && lat < 20) begin @(negedge clk); lat++; end
    chk("ign_lat", 64'(lat), 64'd5);
    chk("ign_sum", 64'(d16.sum), 64'd101);
    nd = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); nd += int'(d16.done); end
    chk("ign_extra_done", 64'(nd), 64'd0);

    // start held high: back-to-back every N+2 = 6 cycles.
    @(negedge clk);
    d16.a = 16'd1; d16.b = 16'd2; d16.sub = 1'b0; d16.start = 1'b1;
    nd = 0; first = 0; last = 0;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (d16.done) begin
        nd++;
        if (nd == 1) first = j;
        last = j;
      end
    end
    d16.start = 1'b0;
    chk("b2b_count", 64'(nd), 64'd3);
    chk("b2b_first", 64'(first), 64'd5);
    chk("b2b_last",  64'(last), 64'd17);
    chk("b2b_sum",   64'(d16.sum), 64'd3);
    repeat (8) @(negedge clk);

    // WIDTH=32, CHUNK=8.
    @(negedge clk);
    d32.a = 32'hFFFF_FFFF; d32.b = 32'd1; d32.sub = 1'b0; d32.start = 1'b1;
    @(negedge clk);
    d32.start = 1'b0;
    lat = 1;
    while (!d32.done && lat < 20) begin @(negedge clk); lat++; end
    chk("w32_lat",  64'(lat), 64'd5);
    chk("w32_sum",  64'(d32.sum), 64'd0);
    chk("w32_cout", 64'(d32.cout), 64'd1);
    chk("w32_ovf",  64'(d32.ovf), 64'd0);

    // CHUNK=WIDTH=16: single RUN cycle.
    @(negedge clk);
    d1c.a = 16'd123; d1c.b = 16'd456; d1c.sub = 1'b0; d1c.start = 1'b1;
    @(negedge clk);
    d1c.start = 1'b0;
    lat = 1;
    while (!d1c.done && lat < 20) begin @(negedge clk); lat++; end
    chk("n1_lat",  64'(lat), 64'd2);
    chk("n1_sum",  64'(d1c.sum), 64'd579);
    chk("n1_cout", 64'(d1c.cout), 64'd0);
    @(negedge clk);
    chk("n1_done_low", 64'(d1c.done), 64'd0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    d16.a = 16'd7; d16.b = 16'd5; d16.sub = 1'b0; d16.start = 1'b1;
    @(negedge clk);
    d16.start = 1'b0;
    chk("abort_prev_sum", 64'(d16.sum), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({d16.busy, d16.done, d16.sum, d16.cout, d16.ovf}), 64'd0);
    chk("abort_w32_sum", 64'(d32.sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nd += int'(d16.done) + int'(d16.busy);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op16("post_abort", 16'd7, 16'd5, 1'b0, 16'd12, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
